// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit common-anode 7-segment driver: shadow-latched digit codes,
// one digit per refresh slot, active-low segment/anode outputs with optional guard time.
module seg7_scan_driver #(
    parameter int N_DIGITS      = 4,
    parameter int REFRESH_DIV   = 100000,
    parameter int GUARD_CYCLES  = 16,
    parameter int HEX_MODE      = 1,
    parameter int BLANK_LEADING = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*N_DIGITS-1:0]   digits_in,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic                    load,
    input  logic                    enable,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [N_DIGITS-1:0]     an,
    output logic                    frame_tick
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = $clog2(N_DIGITS);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_DIGITS - 1);
    localparam logic [CNT_W:0]   GUARD_L = (CNT_W + 1)'(GUARD_CYCLES);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [4*N_DIGITS-1:0] shadow_q, shadow_d;
    logic [N_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [N_DIGITS-1:0]   an_q, an_d;
    logic                  frame_tick_q, frame_tick_d;

    logic [3:0]            cur_code;
    logic                  upper_zero;
    logic                  blank;
    logic                  slot_end;

    function automatic logic [6:0] decode(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'h0:    s = 7'b0000001;
            4'h1:    s = 7'b1001111;
            4'h2:    s = 7'b0010010;
            4'h3:    s = 7'b0000110;
            4'h4:    s = 7'b1001100;
            4'h5:    s = 7'b0100100;
            4'h6:    s = 7'b0100000;
            4'h7:    s = 7'b0001111;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0000100;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b1100000;
            4'hC:    s = 7'b0110001;
            4'hD:    s = 7'b1000010;
            4'hE:    s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        if (HEX_MODE == 0 && code > 4'd9) s = 7'b1111111;
        return s;
    endfunction

    // Leading-zero test looks at the selected digit and everything more significant.
    always_comb begin
        cur_code   = shadow_q[4*idx_q +: 4];
        upper_zero = 1'b1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (i >= int'(idx_q) && shadow_q[4*i +: 4] != 4'd0) upper_zero = 1'b0;
        end
        blank = (BLANK_LEADING != 0) && upper_zero && (idx_q != '0);
    end

    always_comb begin
        slot_end     = (cnt_q == CNT_MAX);
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        frame_tick_d = 1'b0;
        if (enable) begin
            if (slot_end) begin
                cnt_d        = '0;
                idx_d        = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
                frame_tick_d = (idx_q == IDX_MAX);
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        shadow_d    = load ? digits_in : shadow_q;
        shadow_dp_d = load ? dp_in : shadow_dp_q;
    end

    // Outputs follow the pre-edge counter/index/shadow, so they lag the scan state by one cycle.
    always_comb begin
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        an_d  = '1;
        if (enable && ({1'b0, cnt_q} >= GUARD_L)) begin
            an_d[idx_q] = 1'b0;
            seg_d       = blank ? 7'h7F : decode(cur_code);
            dp_d        = ~shadow_dp_q[idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            shadow_q     <= '0;
            shadow_dp_q  <= '0;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
            an_q         <= '1;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            shadow_dp_q  <= shadow_dp_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: three option variants share one stimulus stream,
// expectations come from an arithmetic scan-position model and a glyph table.
module tb_seg7_scan_driver;

    localparam int N  = 4;
    localparam int RD = 4;
    localparam int G  = 1;
    localparam int NI = 3;
    localparam bit [NI-1:0] HX = 3'b011;
    localparam bit [NI-1:0] BL = 3'b010;

    typedef struct packed {
        logic [NI-1:0][6:0] seg;
        logic [NI-1:0]      dp;
        logic [NI-1:0][3:0] an;
        logic [NI-1:0]      ft;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] digits_in = '0;
    logic [3:0]  dp_in = '0;

    logic [6:0] seg_o [NI];
    logic       dp_o  [NI];
    logic [3:0] an_o  [NI];
    logic       ft_o  [NI];

    always #5 clk = ~clk;

    seg7_scan_driver #(.N_DIGITS(N), .REFRESH_DIV(RD), .GUARD_CYCLES(G), .HEX_MODE(1), .BLANK_LEADING(0))
        u0 (.clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in), .load(load), .enable(enable),
            .seg(seg_o[0]), .dp(dp_o[0]), .an(an_o[0]), .frame_tick(ft_o[0]));
    seg7_scan_driver #(.N_DIGITS(N), .REFRESH_DIV(RD), .GUARD_CYCLES(G), .HEX_MODE(1), .BLANK_LEADING(1))
        u1 (.clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in), .load(load), .enable(enable),
            .seg(seg_o[1]), .dp(dp_o[1]), .an(an_o[1]), .frame_tick(ft_o[1]));
    seg7_scan_driver #(.N_DIGITS(N), .REFRESH_DIV(RD), .GUARD_CYCLES(G), .HEX_MODE(0), .BLANK_LEADING(0))
        u2 (.clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in), .load(load), .enable(enable),
            .seg(seg_o[2]), .dp(dp_o[2]), .an(an_o[2]), .frame_tick(ft_o[2]));

    logic [6:0] glyph_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    exp_t exp_q [$];
    bit   started = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    // Reference model: count of enabled cycles since reset defines the scan position.
    int          m_p = 0;
    logic [15:0] m_sh = '0;
    logic [3:0]  m_dp = '0;

    function automatic logic [6:0] glyph(input logic [3:0] code, input bit hex);
        if (code > 4'd9 && !hex) return 7'h7F;
        return glyph_tab[code];
    endfunction

    function automatic int cur_cnt();
        return m_p % RD;
    endfunction

    function automatic int cur_idx();
        return (m_p / RD) % N;
    endfunction

    task automatic step(input bit r, input bit ld, input bit en, input logic [15:0] dg, input logic [3:0] dv);
        exp_t e;
        int cnt, idx;
        logic [3:0] oh;
        @(negedge clk);
        rst = r; load = ld; enable = en; digits_in = dg; dp_in = dv;
        for (int k = 0; k < NI; k++) begin
            e.seg[k] = 7'h7F; e.dp[k] = 1'b1; e.an[k] = 4'hF; e.ft[k] = 1'b0;
        end
        if (r) begin
            m_p = 0; m_sh = '0; m_dp = '0;
        end else begin
            cnt = cur_cnt();
            idx = cur_idx();
            oh  = 4'b0001 << idx;
            for (int k = 0; k < NI; k++) begin
                if (en) e.ft[k] = (cnt == RD - 1) && (idx == N - 1);
                if (en && cnt >= G) begin
                    e.an[k]  = ~oh;
                    e.dp[k]  = ~m_dp[idx];
                    e.seg[k] = (BL[k] && idx != 0 && (m_sh >> (4 * idx)) == 16'd0)
                               ? 7'h7F : glyph(m_sh[4*idx +: 4], HX[k]);
                end
            end
            if (en) m_p++;
            if (ld) begin m_sh = dg; m_dp = dv; end
        end
        exp_q.push_back(e);
        started = 1'b1;
    endtask

    task automatic run(input int n, input bit en);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, en, digits_in, dp_in);
    endtask

    task automatic run_until(input int idx, input int cnt);
        for (int i = 0; i < 64; i++) begin
            if (cur_idx() == idx && cur_cnt() == cnt) return;
            step(1'b0, 1'b0, 1'b1, digits_in, dp_in);
        end
        n_total++;
        $display("FAIL run_until: position idx=%0d cnt=%0d not reached, want idx=%0d cnt=%0d",
                 cur_idx(), cur_cnt(), idx, cnt);
    endtask

    task automatic chk(input string name, input int k, input logic [6:0] act, input logic [6:0] want);
        n_total++;
        if (act === want) n_pass++;
        else $display("FAIL %s[u%0d] t=%0t: got %b, want %b", name, k, $time, act, want);
    endtask

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            if (started) begin
                n_total++;
                $display("FAIL scoreboard: no expectation queued at t=%0t", $time);
            end
        end else begin
            e = exp_q.pop_front();
            for (int k = 0; k < NI; k++) begin
                chk("seg", k, seg_o[k], e.seg[k]);
                chk("dp", k, {6'd0, dp_o[k]}, {6'd0, e.dp[k]});
                chk("an", k, {3'd0, an_o[k]}, {3'd0, e.an[k]});
                chk("frame_tick", k, {6'd0, ft_o[k]}, {6'd0, e.ft[k]});
            end
        end
    end

    initial begin
        logic [15:0] dg;
        step(1'b1, 1'b0, 1'b1, 16'h0000, 4'h0);
        step(1'b1, 1'b1, 1'b1, 16'hFFFF, 4'hF);
        step(1'b0, 1'b1, 1'b1, 16'h1234, 4'h0);
        run(40, 1'b1);
        step(1'b0, 1'b1, 1'b1, 16'h00AF, 4'b0010);
        run(20, 1'b1);
        step(1'b0, 1'b1, 1'b1, 16'hC009, 4'h0);
        run(20, 1'b1);
        run_until(2, 2);
        run(10, 1'b0);
        run(20, 1'b1);
        run_until(3, 2);
        step(1'b1, 1'b0, 1'b1, digits_in, dp_in);
        run(20, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            for (int j = 0; j < 4; j++)
                dg[4*j +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            step($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 9) != 0,
                 dg, 4'($urandom_range(0, 15)));
        end
        @(posedge clk);
        #2;
        started = 1'b0;
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL scoreboard: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
